// File: rtl/tdm_demux4_sync.sv
// Four-slot TDM receiver: hunts for frame_start, collects slots 0..3, publishes a full frame on the slot-3 edge.
// Registered outputs visible one cycle after the completing beat; no backpressure, a beat is consumed when in_valid_i=1.
module tdm_demux4_sync #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic             frame_start_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [1:0]       slot_o,
    output logic [WIDTH-1:0] d0_o,
    output logic [WIDTH-1:0] d1_o,
    output logic [WIDTH-1:0] d2_o,
    output logic [WIDTH-1:0] d3_o,
    output logic             frame_valid_o,
    output logic             sync_err_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic             fv_q, fv_d, se_q, se_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        fv_d    = 1'b0;
        se_d    = 1'b0;
        cnt_d   = cnt_q;
        if (in_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (frame_start_i) begin
                        sh0_d   = din_i;
                        slot_d  = 2'd1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (frame_start_i) begin
                        // A start marker anywhere but slot 0 drops the partial frame and resyncs on this beat.
                        se_d   = (slot_q != 2'd0);
                        sh0_d  = din_i;
                        slot_d = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: begin
                                se_d    = 1'b1;
                                state_d = HUNT;
                                slot_d  = 2'd0;
                            end
                            2'd1: begin
                                sh1_d  = din_i;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = din_i;
                                slot_d = 2'd3;
                            end
                            default: begin
                                d0_d   = sh0_q;
                                d1_d   = sh1_q;
                                d2_d   = sh2_q;
                                d3_d   = din_i;
                                fv_d   = 1'b1;
                                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                                slot_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HUNT;
            slot_q  <= 2'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
            cnt_q   <= cnt_d;
        end
    end

    assign slot_o        = slot_q;
    assign d0_o          = d0_q;
    assign d1_o          = d1_q;
    assign d2_o          = d2_q;
    assign d3_o          = d3_q;
    assign frame_valid_o = fv_q;
    assign sync_err_o    = se_q;
    assign frame_cnt_o   = cnt_q;

endmodule
